// File: rtl/malu_pkg.sv
// malu_pkg: shared types and constants for the mALU sequencing controller.
//   m_op_e       - M-extension funct3 encodings
//   malu_state_e - controller FSM state type, with its state constants
//   XLEN_DEF     - default operand/result width
//   op_signs     - operand signedness {signed_a, signed_b} for a funct3
package malu_pkg;

    localparam int XLEN_DEF = 64;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } m_op_e;

    typedef logic [1:0] malu_state_e;

    localparam malu_state_e ST_IDLE  = 2'd0;
    localparam malu_state_e ST_RUN   = 2'd1;
    localparam malu_state_e ST_DONE  = 2'd2;
    localparam malu_state_e ST_DRAIN = 2'd3;

    // Returns {signed_a, signed_b}.
    function automatic logic [1:0] op_signs(input m_op_e f);
        case (f)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: return 2'b11;
            OP_MULHSU:                       return 2'b10;
            default:                         return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/malu_fmt.sv
// malu_fmt: combinational operand conditioning and result formatting.
//   i_dec_op        in   4       op being decoded (IDLE), {word, funct3}
//   i_rs1, i_rs2    in   XLEN    raw source operands
//   i_run_op        in   4       op currently owned by the mALU
//   i_malu_result   in   2*XLEN  mALU output, {hi,lo} or {rem,quot}
//   o_a, o_b        out  XLEN    conditioned operands for the mALU
//   o_sa, o_sb      out  1       operand signedness
//   o_special       out  1       divide-by-zero or signed overflow, resolved locally
//   o_special_res   out  XLEN    result for a special op
//   o_res           out  XLEN    selected and sign-extended mALU result
module malu_fmt
    import malu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [3:0]        i_dec_op,
    input  logic [XLEN-1:0]   i_rs1,
    input  logic [XLEN-1:0]   i_rs2,
    input  logic [3:0]        i_run_op,
    input  logic [2*XLEN-1:0] i_malu_result,
    output logic [XLEN-1:0]   o_a,
    output logic [XLEN-1:0]   o_b,
    output logic              o_sa,
    output logic              o_sb,
    output logic              o_special,
    output logic [XLEN-1:0]   o_special_res,
    output logic [XLEN-1:0]   o_res
);

    function automatic logic [XLEN-1:0] ext32(input logic [31:0] x, input logic s);
        return {{(XLEN-32){s & x[31]}}, x};
    endfunction

    // ---------------- decode side ----------------
    m_op_e         w_f3;
    logic          w_word;
    logic [1:0]    w_signs;
    logic          w_is_div;
    logic          w_is_rem;
    logic          w_signed_div;
    logic          w_div0;
    logic          w_ovf;
    logic [XLEN-1:0] w_spec_raw;

    assign w_f3    = m_op_e'(i_dec_op[2:0]);
    assign w_word  = i_dec_op[3];
    assign w_signs = op_signs(w_f3);
    assign o_sa    = w_signs[1];
    assign o_sb    = w_signs[0];

    // Word ops see only the low 32 bits, extended according to signedness.
    assign o_a = w_word ? ext32(i_rs1[31:0], o_sa) : i_rs1;
    assign o_b = w_word ? ext32(i_rs2[31:0], o_sb) : i_rs2;

    assign w_is_div     = (w_f3 == OP_DIV) || (w_f3 == OP_DIVU);
    assign w_is_rem     = (w_f3 == OP_REM) || (w_f3 == OP_REMU);
    assign w_signed_div = (w_f3 == OP_DIV) || (w_f3 == OP_REM);

    assign w_div0 = w_word ? (i_rs2[31:0] == 32'd0) : (i_rs2 == '0);
    assign w_ovf  = w_signed_div &
                    (w_word ? ((i_rs1[31:0] == 32'h8000_0000) && (i_rs2[31:0] == 32'hFFFF_FFFF))
                            : ((i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2 == {XLEN{1'b1}})));

    assign o_special = (w_is_div | w_is_rem) & (w_div0 | w_ovf);

    // Divide-by-zero: quotient all-ones, remainder = dividend.
    // Overflow (min / -1): quotient = min (the dividend), remainder = 0.
    always_comb begin
        w_spec_raw = '0;
        if (w_div0)
            w_spec_raw = w_is_div ? {XLEN{1'b1}} : o_a;
        else if (w_ovf)
            w_spec_raw = w_is_div ? o_a : '0;
        o_special_res = w_word ? ext32(w_spec_raw[31:0], 1'b1) : w_spec_raw;
    end

    // ---------------- result side ----------------
    m_op_e           w_rf3;
    logic            w_sel_hi;
    logic [XLEN-1:0] w_sel;

    assign w_rf3 = m_op_e'(i_run_op[2:0]);
    // Low half carries MUL product-lo and the quotient; everything else is the high half.
    assign w_sel_hi = !((w_rf3 == OP_MUL) || (w_rf3 == OP_DIV) || (w_rf3 == OP_DIVU));
    assign w_sel    = w_sel_hi ? i_malu_result[2*XLEN-1:XLEN] : i_malu_result[XLEN-1:0];
    assign o_res    = i_run_op[3] ? ext32(w_sel[31:0], 1'b1) : w_sel;

endmodule

// File: rtl/malu_ctrl.sv
// malu_ctrl: sequencing controller for the multi-cycle mALU in EXC (RV64 M).
//   i_clk, i_reset    in   1       clock, async active-high reset
//   i_req_valid       in   1       M op present in EXA
//   i_op              in   4       {word, funct3}
//   i_rs1, i_rs2      in   XLEN    source operands
//   i_flush           in   1       kill current op
//   o_busy            out  1       pipeline stall request (combinational)
//   o_done            out  1       one-cycle result-valid pulse
//   o_result          out  XLEN    formatted result, held until next done
//   o_timeout_err     out  1       sticky watchdog error
//   o_malu_start      out  1       one-cycle start pulse to mALU
//   o_malu_a/b        out  XLEN    conditioned operands, stable while RUN
//   o_malu_sa/sb      out  1       operand signedness to mALU
//   i_malu_result     in   2*XLEN  {hi,lo} product or {rem,quot}
//   i_malu_ready      in   1       mALU result valid (level)
module malu_ctrl
    import malu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    input  logic [3:0]        i_op,
    input  logic [XLEN-1:0]   i_rs1,
    input  logic [XLEN-1:0]   i_rs2,
    input  logic              i_flush,
    output logic              o_busy,
    output logic              o_done,
    output logic [XLEN-1:0]   o_result,
    output logic              o_timeout_err,
    output logic              o_malu_start,
    output logic [XLEN-1:0]   o_malu_a,
    output logic [XLEN-1:0]   o_malu_b,
    output logic              o_malu_sa,
    output logic              o_malu_sb,
    input  logic [2*XLEN-1:0] i_malu_result,
    input  logic              i_malu_ready
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    malu_state_e     r_state;
    logic            r_start;
    logic            r_timeout;
    logic [XLEN-1:0] r_result;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic            r_sa;
    logic            r_sb;
    logic [3:0]      r_op;
    logic [7:0]      r_cnt;

    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_sa;
    logic            w_sb;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic [XLEN-1:0] w_res;
    logic            w_accept;

    malu_fmt #(.XLEN(XLEN)) u_fmt (
        .i_dec_op      (i_op),
        .i_rs1         (i_rs1),
        .i_rs2         (i_rs2),
        .i_run_op      (r_op),
        .i_malu_result (i_malu_result),
        .o_a           (w_a),
        .o_b           (w_b),
        .o_sa          (w_sa),
        .o_sb          (w_sb),
        .o_special     (w_special),
        .o_special_res (w_special_res),
        .o_res         (w_res)
    );

    assign w_accept = (r_state == ST_IDLE) && i_req_valid && !i_flush;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_start   <= 1'b0;
            r_timeout <= 1'b0;
            r_result  <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_op      <= '0;
            r_cnt     <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a  <= w_a;
                        r_b  <= w_b;
                        r_sa <= w_sa;
                        r_sb <= w_sb;
                        r_op <= i_op;
                        if (w_special) begin
                            // Resolved locally; the mALU is never started.
                            r_result <= w_special_res;
                            r_state  <= ST_DONE;
                        end else begin
                            r_start <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // Flush beats a same-cycle ready: the result is discarded.
                    if (i_flush) begin
                        r_state <= ST_DRAIN;
                    end else if (i_malu_ready) begin
                        r_result <= w_res;
                        r_state  <= ST_DONE;
                    end else if (r_cnt == TIMEOUT_CNT) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                    if (r_cnt != 8'hFF)
                        r_cnt <= r_cnt + 8'd1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                ST_DRAIN: begin
                    // Wait out the killed op so the mALU is free for the next one.
                    if (i_malu_ready)
                        r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall must take effect in the decode cycle, hence combinational on req_valid.
    assign o_busy        = w_accept || (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign o_done        = (r_state == ST_DONE);
    assign o_result      = r_result;
    assign o_timeout_err = r_timeout;
    assign o_malu_start  = r_start;
    assign o_malu_a      = r_a;
    assign o_malu_b      = r_b;
    assign o_malu_sa     = r_sa;
    assign o_malu_sb     = r_sb;

endmodule

// File: tb/tb_malu_ctrl.sv
// tb_malu_ctrl: directed self-checking bench for malu_ctrl with a result scoreboard.
module tb_malu_ctrl;

    logic         clk;
    logic         reset;
    logic         req_valid;
    logic [3:0]   op;
    logic [63:0]  rs1;
    logic [63:0]  rs2;
    logic         flush;
    logic         busy;
    logic         done;
    logic [63:0]  result;
    logic         timeout_err;
    logic         malu_start;
    logic [63:0]  malu_a;
    logic [63:0]  malu_b;
    logic         malu_sa;
    logic         malu_sb;
    logic [127:0] malu_result;
    logic         malu_ready;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    int n_pushed = 0;
    int busy_cnt;
    int start_cnt;
    logic [63:0] exp_q[$];

    malu_ctrl #(.XLEN(64), .TIMEOUT(255)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_req_valid   (req_valid),
        .i_op          (op),
        .i_rs1         (rs1),
        .i_rs2         (rs2),
        .i_flush       (flush),
        .o_busy        (busy),
        .o_done        (done),
        .o_result      (result),
        .o_timeout_err (timeout_err),
        .o_malu_start  (malu_start),
        .o_malu_a      (malu_a),
        .o_malu_b      (malu_b),
        .o_malu_sa     (malu_sa),
        .o_malu_sb     (malu_sb),
        .i_malu_result (malu_result),
        .i_malu_ready  (malu_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] v);
        exp_q.push_back(v);
        n_pushed++;
    endtask

    // Presents a request at a falling edge and checks the same-cycle stall.
    task automatic issue(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        req_valid = 1'b1;
        op  = o;
        rs1 = a;
        rs2 = b;
        #1 check("busy_decode", busy, 1);
    endtask

    // Scoreboard: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (!reset && done) begin
            done_seen++;
            if (exp_q.size() == 0)
                check("spurious_done", exp_q.size(), 1);
            else
                check("result", result, exp_q.pop_front());
        end
    end

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        op          = 4'd0;
        rs1         = '0;
        rs2         = '0;
        flush       = 1'b0;
        malu_result = '0;
        malu_ready  = 1'b0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_start", malu_start, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_result", result, 0);
        check("rst_malu_a", malu_a, 0);
        @(negedge clk);
        reset = 1'b0;

        // ---- MUL 3 * -4, ready in 5th RUN cycle ----
        issue(4'b0000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC);
        push_exp(64'hFFFF_FFFF_FFFF_FFF4);
        busy_cnt    = int'(busy);
        malu_result = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF4};
        start_cnt   = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (k == 5) malu_ready = 1'b1;
            #1;
            busy_cnt  += int'(busy);
            start_cnt += int'(malu_start);
            if (k == 1) begin
                check("mul_start", malu_start, 1);
                check("mul_a", malu_a, 64'd3);
                check("mul_b", malu_b, 64'hFFFF_FFFF_FFFF_FFFC);
                check("mul_signs", {malu_sa, malu_sb}, 2'b11);
            end
        end
        check("mul_start_pulses", start_cnt, 1);
        check("mul_busy_cycles", busy_cnt, 6);
        @(negedge clk);
        malu_ready = 1'b0;
        #1;
        check("mul_done", done, 1);
        check("mul_busy_done", busy, 0);

        // ---- MULHSU -1 * 2 ----
        issue(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        push_exp(64'hFFFF_FFFF_FFFF_FFFF);
        malu_result = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
        @(negedge clk);
        req_valid = 1'b0;
        #1 check("mulhsu_signs", {malu_sa, malu_sb}, 2'b10);
        @(negedge clk);
        malu_ready = 1'b1;
        @(negedge clk);
        malu_ready = 1'b0;
        #1 check("mulhsu_done", done, 1);

        // ---- DIV 7 / 0 and REM 7 / 0: local, latency 1 ----
        issue(4'b0100, 64'd7, 64'd0);
        push_exp(64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("div0_nostart", malu_start, 0);
        check("div0_done", done, 1);
        check("div0_busy", busy, 0);
        issue(4'b0110, 64'd7, 64'd0);
        push_exp(64'd7);
        @(negedge clk);
        req_valid = 1'b0;
        #1 check("rem0_done", done, 1);

        // ---- DIVW / REMW overflow ----
        issue(4'b1100, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        push_exp(64'hFFFF_FFFF_8000_0000);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("divw_ovf_nostart", malu_start, 0);
        check("divw_ovf_done", done, 1);
        issue(4'b1110, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        push_exp(64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        // 64-bit DIV min / -1 -> min
        issue(4'b0100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        push_exp(64'h8000_0000_0000_0000);
        @(negedge clk);
        req_valid = 1'b0;

        // ---- DIVUW through the mALU: zext operands, sext result ----
        issue(4'b1101, 64'hFFFF_FFFF_0000_0010, 64'h1234_5678_0000_0003);
        push_exp(64'hFFFF_FFFF_8000_0005);
        malu_result = {64'd1, 64'h0000_0000_8000_0005};
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("divuw_a", malu_a, 64'h10);
        check("divuw_b", malu_b, 64'h3);
        check("divuw_signs", {malu_sa, malu_sb}, 2'b00);
        malu_ready = 1'b1;
        @(negedge clk);
        malu_ready = 1'b0;

        // ---- flush together with req in IDLE: no stall ----
        @(negedge clk);
        req_valid = 1'b1;
        flush     = 1'b1;
        #1 check("flush_idle_busy", busy, 0);
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        #1 check("flush_idle_nostart", malu_start, 0);

        // ---- flush 2 cycles into RUN, drain, next op waits for ready ----
        issue(4'b0000, 64'd11, 64'd13);
        malu_result = {64'hDEAD, 64'hBEEF};
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        flush      = 1'b1;
        malu_ready = 1'b1;       // flush wins over a same-cycle ready
        @(negedge clk);
        flush      = 1'b0;
        malu_ready = 1'b0;
        req_valid  = 1'b1;
        op         = 4'b0011;    // MULHU queued behind the drain
        rs1        = 64'd5;
        rs2        = 64'd6;
        #1 check("drain_busy", busy, 1);
        start_cnt = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 2) malu_ready = 1'b1;
            #1 start_cnt += int'(malu_start);
        end
        malu_ready = 1'b0;
        check("drain_nostart", start_cnt, 0);
        push_exp(64'h1234);
        malu_result = {64'h1234, 64'd30};
        @(negedge clk);
        req_valid = 1'b0;
        #1 check("post_drain_start", malu_start, 1);
        check("post_drain_a", malu_a, 64'd5);
        malu_ready = 1'b1;
        @(negedge clk);
        malu_ready = 1'b0;
        #1 check("post_drain_done", done, 1);

        // ---- watchdog: ready withheld ----
        issue(4'b0000, 64'd9, 64'd9);
        busy_cnt = 0;
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1 busy_cnt += int'(busy);
            if (k == 256) check("timeout_not_early", timeout_err, 0);
        end
        check("timeout_run_cycles", busy_cnt, 256);
        @(negedge clk);
        #1;
        check("timeout_err", timeout_err, 1);
        check("timeout_idle", busy, 0);
        check("result_held", result, 64'h1234);

        // ---- reset while RUN ----
        issue(4'b0001, 64'd21, 64'd22);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        check("rstrun_busy", busy, 0);
        check("rstrun_start", malu_start, 0);
        check("rstrun_timeout", timeout_err, 0);
        check("rstrun_result", result, 0);
        check("rstrun_malu_b", malu_b, 0);
        @(negedge clk);
        reset = 1'b0;
        malu_ready = 1'b1;
        repeat (3) @(negedge clk);
        malu_ready = 1'b0;
        #1 check("rstrun_idle", busy, 0);

        // ---- scoreboard drained, one done per expected result ----
        check("sb_empty", exp_q.size(), 0);
        check("done_count", done_seen, n_pushed);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
